mem_access_stage: RTL
=====================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 7, giving 2**DEPTH_LOG2 32-bit data-memory words.
REQ-002 The block SHALL have parameter WAIT_CYC, default 0, range 0..7, the memory wait states per load/store.
REQ-003 The block SHALL have port clk, input, 1, the single clock (all state on rising edge).
REQ-004 The block SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-005 The block SHALL have port xm_valid, input, 1, X/M register holds a valid instruction.
REQ-006 The block SHALL have port xm_alu_out, input, 32, ALU result or byte address.
REQ-007 The block SHALL have port xm_store_data, input, 32, store data (rt value).
REQ-008 The block SHALL have port xm_rd, input, 5, destination register.
REQ-009 The block SHALL have port xm_mem_rd, input, 1, load.
REQ-010 The block SHALL have port xm_mem_wr, input, 1, store.
REQ-011 The block SHALL have port xm_size, input, 2, 00 byte, 01 half, 10 word, 11 reserved as word.
REQ-012 The block SHALL have port xm_unsigned, input, 1, zero-extend load.
REQ-013 The block SHALL have port stall, output, 1, upstream holds X/M inputs.
REQ-014 The block SHALL have port mw_valid, output, 1, M/W register valid.
REQ-015 The block SHALL have port mw_alu_out, output, 32, write-back value.
REQ-016 The block SHALL have port mw_rd, output, 5, write-back register.
REQ-017 The block SHALL have port mw_reg_wr, output, 1, write-back enable.
REQ-018 The block SHALL have port mw_exc, output, 1, misaligned-access flag (see Configuration).

Function
REQ-019 Memory op SHALL mean xm_valid and (xm_mem_rd or xm_mem_wr); if both are set, load takes priority and no write occurs.
REQ-020 Word index SHALL be xm_alu_out[DEPTH_LOG2+1:2]; higher address bits ignored (wrap-around); lanes little-endian, byte lane = addr[1:0], half lane = addr[1].
REQ-021 Non-memory op: at next edge mw_alu_out<=xm_alu_out, mw_rd<=xm_rd, mw_reg_wr<=1, mw_valid<=1; stall stays 0.
REQ-022 xm_valid=0: at next edge mw_valid<=0, mw_reg_wr<=0; other mw_* hold.
REQ-023 FSM SHALL have states IDLE and WAIT, plus a 3-bit wait counter cnt.
REQ-024 WAIT_CYC=0: memory op completes at the next edge (one-cycle latency), stall never asserted, FSM stays IDLE.
REQ-025 WAIT_CYC=N>0, IDLE with memory op: stall=1 combinationally; next edge -> WAIT, cnt<=N-1, mw_valid<=0, mw_reg_wr<=0.
REQ-026 WAIT: stall=(cnt!=0); cnt!=0 -> decrement; cnt==0 -> access performed at that edge, mw_* updated, -> IDLE; net N stall cycles, N+1 cycles occupancy.
REQ-027 Load completion: mw_alu_out<=selected lane, sign-extended unless xm_unsigned; mw_rd<=xm_rd; mw_reg_wr<=1; mw_valid<=1.
REQ-028 Store completion: write only addressed lanes with low bytes of xm_store_data; mw_rd<=0; mw_reg_wr<=0; mw_valid<=1.
REQ-029 Back-to-back store then load to same word SHALL return the newly written value.
REQ-030 Data memory SHALL be uninitialised and unaffected by reset.

Reset
REQ-031 rst low SHALL immediately force state IDLE, cnt 0, stall 0, mw_valid 0, mw_alu_out 0, mw_rd 0, mw_reg_wr 0, mw_exc 0.
REQ-032 Reset during WAIT SHALL abandon the access; no memory write occurs.
REQ-033 After rst deasserts, the first rising edge SHALL process inputs normally.

Configuration
REQ-034 Macro MEM_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 completes with mw_exc=1, mw_reg_wr=0, no write; mw_exc=0 on every other completion.
REQ-035 MEM_MISALIGN_TRAP_EN undefined: address low bits forced aligned (half ignores addr[0], word ignores addr[1:0]); mw_exc tied 0.

Verification
REQ-036 WAIT_CYC=0: sw 0xDEADBEEF to 0x10, then lw 0x10 rd=5 -> mw_alu_out=0xDEADBEEF, mw_rd=5, mw_reg_wr=1 one cycle after lw, stall never 1.
REQ-037 Byte lanes: sw 0x11223344 to 0x20, sb 0x80 to 0x21, lb 0x21 -> 0xFFFFFF80; lbu -> 0x00000080; lw -> 0x11228044.
REQ-038 WAIT_CYC=3: lw held at inputs -> stall high 3 cycles, mw_valid 0 during them, result valid 4 cycles after presentation; add follows with no stall.
REQ-039 WAIT_CYC=3: sw issued, rst pulsed low in second stall cycle -> outputs zero immediately, later lw of that word does not see store data.
REQ-040 Address 0x200+0x10 with DEPTH_LOG2=7 -> aliases word 4; with MEM_MISALIGN_TRAP_EN, lw 0x12 -> mw_exc=1, mw_reg_wr=0; without, returns word at 0x10.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// X/M -> M/W bus of the memory-access pipeline stage.
// master: upstream pipeline (drives X/M fields, observes stall and M/W).
// slave : mem_access_stage (consumes X/M fields, drives stall and M/W).
interface mem_access_stage_if;
  logic        xm_valid;
  logic [31:0] xm_alu_out;
  logic [31:0] xm_store_data;
  logic [4:0]  xm_rd;
  logic        xm_mem_rd;
  logic        xm_mem_wr;
  logic [1:0]  xm_size;
  logic        xm_unsigned;
  logic        stall;
  logic        mw_valid;
  logic [31:0] mw_alu_out;
  logic [4:0]  mw_rd;
  logic        mw_reg_wr;
  logic        mw_exc;

  modport master (
    output xm_valid, xm_alu_out, xm_store_data, xm_rd,
           xm_mem_rd, xm_mem_wr, xm_size, xm_unsigned,
    input  stall, mw_valid, mw_alu_out, mw_rd, mw_reg_wr, mw_exc
  );

  modport slave (
    input  xm_valid, xm_alu_out, xm_store_data, xm_rd,
           xm_mem_rd, xm_mem_wr, xm_size, xm_unsigned,
    output stall, mw_valid, mw_alu_out, mw_rd, mw_reg_wr, mw_exc
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: little-endian byte/half/word loads and
// stores into a private 2**DEPTH_LOG2 x 32 data memory, with WAIT_CYC
// wait states per access and a registered M/W output register.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned half/word
// accesses flag mw_exc instead of being silently aligned).
module mem_access_stage #(
  parameter int DEPTH_LOG2 = 7,
  parameter int WAIT_CYC   = 0
) (
  input logic                clk,
  input logic                rst,
  mem_access_stage_if.slave  bus
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  localparam int         WORDS    = 1 << DEPTH_LOG2;
  localparam logic [2:0] CNT_INIT = 3'(WAIT_CYC - 1);
  localparam logic       HAS_WAIT = (WAIT_CYC != 0);

  logic [31:0] mem_q [WORDS];

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        mw_valid_q, mw_valid_d;
  logic [31:0] mw_alu_out_q, mw_alu_out_d;
  logic [4:0]  mw_rd_q, mw_rd_d;
  logic        mw_reg_wr_q, mw_reg_wr_d;
  logic        mw_exc_q, mw_exc_d;

  logic                  mem_op_s, is_load_s, is_store_s;
  logic                  misalign_s, stall_s, we_s;
  logic [DEPTH_LOG2-1:0] idx_s;
  logic [1:0]            off_s;
  logic [3:0]            be_s;
  logic [31:0]           wdata_s, rword_s, load_val_s;
  logic [7:0]            lbyte_s;
  logic [15:0]           lhalf_s;
  logic                  unused_s;

  // Address bits above the memory size are ignored: accesses wrap around.
  assign unused_s = ^bus.xm_alu_out[31:DEPTH_LOG2+2];

  // Decode the access: lane offset, byte enables, store data and load result.
  always_comb begin
    mem_op_s   = bus.xm_valid & (bus.xm_mem_rd | bus.xm_mem_wr);
    is_load_s  = mem_op_s & bus.xm_mem_rd;
    is_store_s = mem_op_s & ~bus.xm_mem_rd;
    idx_s      = bus.xm_alu_out[DEPTH_LOG2+1:2];
    case (bus.xm_size)
      2'b00: begin
        off_s   = bus.xm_alu_out[1:0];
        be_s    = 4'b0001 << bus.xm_alu_out[1:0];
        wdata_s = {4{bus.xm_store_data[7:0]}};
      end
      2'b01: begin
        off_s   = {bus.xm_alu_out[1], 1'b0};
        be_s    = bus.xm_alu_out[1] ? 4'b1100 : 4'b0011;
        wdata_s = {2{bus.xm_store_data[15:0]}};
      end
      default: begin
        off_s   = 2'b00;
        be_s    = 4'b1111;
        wdata_s = bus.xm_store_data;
      end
    endcase
`ifdef MEM_MISALIGN_TRAP_EN
    misalign_s = mem_op_s &
                 (((bus.xm_size == 2'b01) & bus.xm_alu_out[0]) |
                  (bus.xm_size[1] & (bus.xm_alu_out[1:0] != 2'b00)));
`else
    misalign_s = 1'b0;
`endif
    rword_s = mem_q[idx_s];
    lbyte_s = rword_s[{off_s, 3'b000} +: 8];
    lhalf_s = off_s[1] ? rword_s[31:16] : rword_s[15:0];
    case (bus.xm_size)
      2'b00:   load_val_s = bus.xm_unsigned ? {24'h000000, lbyte_s}
                                            : {{24{lbyte_s[7]}}, lbyte_s};
      2'b01:   load_val_s = bus.xm_unsigned ? {16'h0000, lhalf_s}
                                            : {{16{lhalf_s[15]}}, lhalf_s};
      default: load_val_s = rword_s;
    endcase
  end

  // Stall while an access is counting down; never while in reset.
  always_comb begin
    if (!rst) begin
      stall_s = 1'b0;
    end else if (state_q == S_WAIT) begin
      stall_s = (cnt_q != 3'd0);
    end else begin
      stall_s = mem_op_s & HAS_WAIT;
    end
    we_s = rst & ~stall_s & is_store_s & ~misalign_s;
  end

  // Next-state and next M/W contents; the access completes when not stalled.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mw_valid_d   = mw_valid_q;
    mw_alu_out_d = mw_alu_out_q;
    mw_rd_d      = mw_rd_q;
    mw_reg_wr_d  = mw_reg_wr_q;
    mw_exc_d     = mw_exc_q;
    if (stall_s) begin
      mw_valid_d  = 1'b0;
      mw_reg_wr_d = 1'b0;
      state_d     = S_WAIT;
      if (state_q == S_IDLE) begin
        cnt_d = CNT_INIT;
      end else begin
        cnt_d = cnt_q - 3'd1;
      end
    end else begin
      state_d = S_IDLE;
      cnt_d   = 3'd0;
      if (!bus.xm_valid) begin
        mw_valid_d  = 1'b0;
        mw_reg_wr_d = 1'b0;
      end else if (!mem_op_s) begin
        mw_alu_out_d = bus.xm_alu_out;
        mw_rd_d      = bus.xm_rd;
        mw_reg_wr_d  = 1'b1;
        mw_valid_d   = 1'b1;
        mw_exc_d     = 1'b0;
      end else if (misalign_s) begin
        // Report the faulting address; nothing is written anywhere.
        mw_alu_out_d = bus.xm_alu_out;
        mw_rd_d      = is_load_s ? bus.xm_rd : 5'd0;
        mw_reg_wr_d  = 1'b0;
        mw_valid_d   = 1'b1;
        mw_exc_d     = 1'b1;
      end else if (is_load_s) begin
        mw_alu_out_d = load_val_s;
        mw_rd_d      = bus.xm_rd;
        mw_reg_wr_d  = 1'b1;
        mw_valid_d   = 1'b1;
        mw_exc_d     = 1'b0;
      end else begin
        mw_rd_d     = 5'd0;
        mw_reg_wr_d = 1'b0;
        mw_valid_d  = 1'b1;
        mw_exc_d    = 1'b0;
      end
    end
  end

  // FSM and M/W register; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 3'd0;
      mw_valid_q   <= 1'b0;
      mw_alu_out_q <= 32'h0000_0000;
      mw_rd_q      <= 5'd0;
      mw_reg_wr_q  <= 1'b0;
      mw_exc_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mw_valid_q   <= mw_valid_d;
      mw_alu_out_q <= mw_alu_out_d;
      mw_rd_q      <= mw_rd_d;
      mw_reg_wr_q  <= mw_reg_wr_d;
      mw_exc_q     <= mw_exc_d;
    end
  end

  // Data memory: byte-lane writes, contents untouched by reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we_s && be_s[i]) begin
        mem_q[idx_s][i*8 +: 8] <= wdata_s[i*8 +: 8];
      end
    end
  end

  assign bus.stall      = stall_s;
  assign bus.mw_valid   = mw_valid_q;
  assign bus.mw_alu_out = mw_alu_out_q;
  assign bus.mw_rd      = mw_rd_q;
  assign bus.mw_reg_wr  = mw_reg_wr_q;
  assign bus.mw_exc     = mw_exc_q;

endmodule
